// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter: FSM states and the
// owner encoding, which doubles as the 2:1 address mux select.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// Loadable down-counter with a zero flag; saturates at zero when asked to
// decrement past it, so it is safe to reuse for other multi-cycle units.
module lat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between fetch
// and data access; every access runs IDLE -> ACCESS -> WAIT -> IDLE.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic dm_req,
  input  logic dm_we,
  output logic addr_sel,
  output logic mem_en,
  output logic mem_we,
  output logic if_gnt,
  output logic dm_gnt,
  output logic if_done,
  output logic dm_done,
  output logic busy
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

  // Handshake: a requester holds req high until its done pulse; grant and
  // done are single-cycle pulses and req is only looked at while IDLE.
  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_owner_q, last_owner_d;
  logic   we_q, we_d;
  logic   winner;
  logic   cnt_load;
  logic   cnt_dec;
  logic   cnt_zero;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    winner       = OWN_IF;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // With both requesting, the side that did not go last wins.
        if (if_req && dm_req) begin
          winner = ~last_owner_q;
        end else if (dm_req) begin
          winner = OWN_DM;
        end else begin
          winner = OWN_IF;
        end
        if (if_req || dm_req) begin
          state_d      = ACCESS;
          owner_d      = winner;
          last_owner_d = winner;
          we_d         = (winner == OWN_DM) && dm_we;
        end
      end
      ACCESS: begin
        cnt_load = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (cnt_zero) begin
          state_d = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_DM;
      we_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
    end
  end

  lat_counter #(
    .W(CNT_W)
  ) u_lat_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (LAT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Outputs are pure decodes of registered state, so they are glitch-free
  // and drop to zero in the cycle after a reset edge.
  assign addr_sel = owner_q;
  assign mem_en   = (state_q == ACCESS);
  assign mem_we   = (state_q == ACCESS) && we_q;
  assign if_gnt   = (state_q == ACCESS) && (owner_q == OWN_IF);
  assign dm_gnt   = (state_q == ACCESS) && (owner_q == OWN_DM);
  assign if_done  = (state_q == WAIT) && cnt_zero && (owner_q == OWN_IF);
  assign dm_done  = (state_q == WAIT) && cnt_zero && (owner_q == OWN_DM);
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=2 and one
// with MEM_LAT=1 share the inputs; each step drives a cycle and checks it.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic if_req = 1'b0;
  logic dm_req = 1'b0;
  logic dm_we = 1'b0;

  logic addr_sel0, mem_en0, mem_we0, if_gnt0, dm_gnt0, if_done0, dm_done0, busy0;
  logic addr_sel1, mem_en1, mem_we1, if_gnt1, dm_gnt1, if_done1, dm_done1, busy1;
  logic [7:0] out0, out1;

  int n_checks = 0;
  int n_err = 0;

  // clock / reset
  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(2), .CNT_W(4)) u_dut0 (
    .clk(clk), .rst(rst), .if_req(if_req), .dm_req(dm_req), .dm_we(dm_we),
    .addr_sel(addr_sel0), .mem_en(mem_en0), .mem_we(mem_we0),
    .if_gnt(if_gnt0), .dm_gnt(dm_gnt0), .if_done(if_done0), .dm_done(dm_done0),
    .busy(busy0)
  );

  mem_port_arbiter #(.MEM_LAT(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .if_req(if_req), .dm_req(dm_req), .dm_we(dm_we),
    .addr_sel(addr_sel1), .mem_en(mem_en1), .mem_we(mem_we1),
    .if_gnt(if_gnt1), .dm_gnt(dm_gnt1), .if_done(if_done1), .dm_done(dm_done1),
    .busy(busy1)
  );

  // {busy, dm_done, if_done, dm_gnt, if_gnt, mem_we, mem_en, addr_sel}
  assign out0 = {busy0, dm_done0, if_done0, dm_gnt0, if_gnt0, mem_we0, mem_en0, addr_sel0};
  assign out1 = {busy1, dm_done1, if_done1, dm_gnt1, if_gnt1, mem_we1, mem_en1, addr_sel1};

  // scoreboard
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (busy,dm_done,if_done,dm_gnt,if_gnt,mem_we,mem_en,addr_sel)",
               tag, got, exp);
    end
  endtask

  // driver: vin = {rst, if_req, dm_req, dm_we}; check mid-cycle, then advance
  task automatic step(input string tag, input logic [3:0] vin, input logic [7:0] exp,
                      input logic use1);
    {rst, if_req, dm_req, dm_we} = vin;
    #3;
    check(tag, use1 ? out1 : out0, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    {rst, if_req, dm_req, dm_we} = 4'b1000;
    @(posedge clk);
    #1;
    check({tag, " rst0"}, out0, 8'h00);
    check({tag, " rst1"}, out1, 8'h00);
  endtask

  initial begin
    @(posedge clk);
    #1;

    do_reset("fetch");
    step("fetch c1", 4'b0100, 8'h00, 1'b0);
    step("fetch c2", 4'b0100, 8'h8A, 1'b0);
    step("fetch c3", 4'b0100, 8'h80, 1'b0);
    step("fetch c4", 4'b0000, 8'hA0, 1'b0);
    step("fetch c5", 4'b0000, 8'h00, 1'b0);

    // dm_we dropping after the grant must not affect the write strobe
    do_reset("store");
    step("store c1", 4'b0011, 8'h00, 1'b0);
    step("store c2", 4'b0010, 8'h97, 1'b0);
    step("store c3", 4'b0011, 8'h81, 1'b0);
    step("store c4", 4'b0000, 8'hC1, 1'b0);
    step("store c5", 4'b0000, 8'h01, 1'b0);

    do_reset("contend");
    step("contend c1", 4'b0110, 8'h00, 1'b0);
    step("contend c2", 4'b0110, 8'h8A, 1'b0);
    step("contend c3", 4'b0110, 8'h80, 1'b0);
    step("contend c4", 4'b0110, 8'hA0, 1'b0);
    step("contend c5", 4'b0110, 8'h00, 1'b0);
    step("contend c6", 4'b0110, 8'h93, 1'b0);
    step("contend c7", 4'b0110, 8'h81, 1'b0);
    step("contend c8", 4'b0110, 8'hC1, 1'b0);
    step("contend c9", 4'b0110, 8'h01, 1'b0);
    step("contend c10", 4'b0100, 8'h8A, 1'b0);
    step("contend c11", 4'b0100, 8'h80, 1'b0);
    step("contend c12", 4'b0000, 8'hA0, 1'b0);
    step("contend c13", 4'b0000, 8'h00, 1'b0);

    do_reset("lat1");
    step("lat1 c1", 4'b0010, 8'h00, 1'b1);
    step("lat1 c2", 4'b0010, 8'h93, 1'b1);
    step("lat1 c3", 4'b0000, 8'hC1, 1'b1);
    step("lat1 c4", 4'b0000, 8'h01, 1'b1);
    step("lat1 c5", 4'b0000, 8'h01, 1'b1);

    // reset lands in WAIT; the fetch that would have completed is dropped
    do_reset("midrst");
    step("midrst c1", 4'b0100, 8'h00, 1'b0);
    step("midrst c2", 4'b0100, 8'h8A, 1'b0);
    step("midrst c3", 4'b1010, 8'h80, 1'b0);
    step("midrst c4", 4'b0010, 8'h00, 1'b0);
    step("midrst c5", 4'b0010, 8'h93, 1'b0);
    step("midrst c6", 4'b0010, 8'h81, 1'b0);
    step("midrst c7", 4'b0000, 8'hC1, 1'b0);
    step("midrst c8", 4'b0000, 8'h01, 1'b0);

    do_reset("drop");
    step("drop c1", 4'b0100, 8'h00, 1'b0);
    step("drop c2", 4'b0110, 8'h8A, 1'b0);
    step("drop c3", 4'b0010, 8'h80, 1'b0);
    step("drop c4", 4'b0010, 8'hA0, 1'b0);
    step("drop c5", 4'b0010, 8'h00, 1'b0);
    step("drop c6", 4'b0010, 8'h93, 1'b0);
    step("drop c7", 4'b0010, 8'h81, 1'b0);
    step("drop c8", 4'b0000, 8'hC1, 1'b0);
    step("drop c9", 4'b0000, 8'h01, 1'b0);

    // final report
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the core's single unified memory port between instruction fetch (IF) and data access (DM).
- Sequences each access through a fixed-latency memory.
- Drives the select of the 32-bit 2:1 address mux (0 = fetch address, 1 = data address) and the memory enable and write strobes.
- Round-robin on contention, so neither requester starves.

Parameters:
- MEM_LAT, 2, memory read latency in cycles from the enable cycle to read-data-valid; legal range 1..15.
- CNT_W, 4, width of the latency counter; must hold MEM_LAT.

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  synchronous reset, active high
- if_req  input  1  fetch request; held until if_done
- dm_req  input  1  data request; held until dm_done
- dm_we  input  1  data request is a store; sampled in the grant cycle
- addr_sel  output  1  address/write-data mux select: 0 = IF, 1 = DM
- mem_en  output  1  memory enable, one-cycle pulse per access
- mem_we  output  1  memory write strobe, only ever high together with mem_en
- if_gnt  output  1  one-cycle pulse: IF access issued this cycle
- dm_gnt  output  1  one-cycle pulse: DM access issued this cycle
- if_done  output  1  one-cycle pulse: IF read data valid / access complete
- dm_done  output  1  one-cycle pulse: DM access complete (read data valid for loads)
- busy  output  1  high from grant through done inclusive

Behaviour:
- States: IDLE, ACCESS, WAIT. Registered state, owner (1 bit), last_owner (1 bit), counter (CNT_W bits).
- Reset (rst=1 at a clock edge):
  - state=IDLE, owner=0, last_owner=1 (DM), counter=0.
  - All outputs 0; addr_sel=0.
  - Reset mid-transaction abandons the access; no done pulse is issued.
- IDLE:
  - No request: stay; all pulses 0; addr_sel holds owner.
  - Exactly one request: grant it.
  - Both requesting: grant the requester that is not last_owner. After reset this means IF wins first.
  - Grant decision is registered: next state=ACCESS, owner=winner, last_owner=winner.
- ACCESS (exactly one cycle):
  - mem_en=1, addr_sel=owner.
  - mem_we = owner==DM and dm_we sampled in IDLE; mem_we=0 for IF.
  - The gnt pulse matching owner is high.
  - counter loads MEM_LAT-1.
  - If MEM_LAT=1, go to IDLE and pulse done in the next cycle via WAIT with counter=0. The uniform rule: done is always asserted in WAIT when counter==0.
  - Otherwise go to WAIT.
- WAIT:
  - addr_sel holds owner; mem_en=0.
  - counter decrements each cycle.
  - When counter==0: done pulse for owner, next state=IDLE.
- Latency:
  - Request seen in IDLE at cycle T gives gnt/mem_en at T+1 and done at T+1+MEM_LAT.
  - Back-to-back: the requester drops req in the done cycle, and the next grant decision is made in the following IDLE cycle.
- The other requester's req arriving or holding during ACCESS/WAIT is ignored until IDLE.
- Owner's req deasserting mid-access: the access still completes and done is still pulsed.
- dm_we changing after the grant has no effect.
- At most one of if_gnt/dm_gnt and one of if_done/dm_done is high in any cycle.
- busy = (state != IDLE).

Decomposition:
- Shared core package:
  - state enum {IDLE, ACCESS, WAIT}.
  - Owner constants OWN_IF=1'b0, OWN_DM=1'b1, which match the 2:1 mux select encoding.
- One natural sub-module: lat_counter, a loadable down-counter with zero flag, reusable for other multi-cycle units.
- Arbitration logic stays inline.

Test Plan:
- Single fetch, MEM_LAT=2: if_req=1 at cycle 1 -> if_gnt/mem_en=1, addr_sel=0, mem_we=0 at cycle 2; if_done at cycle 4; busy high cycles 2-4.
- Store, MEM_LAT=2: dm_req=1, dm_we=1 at cycle 1 -> dm_gnt, mem_en, mem_we=1, addr_sel=1 at cycle 2; dm_done at cycle 4; mem_we low at cycles 3-4.
- Contention after reset: both req held from cycle 1 -> IF granted at cycle 2; DM granted at cycle 6 (after if_done at 4 and IDLE at 5); the third grant goes to IF.
- MEM_LAT=1: single dm load -> dm_gnt at T+1, dm_done at T+2, never two mem_en pulses per access.
- Reset mid-access: rst=1 during WAIT -> next cycle all outputs 0, no done pulse; after release a pending dm_req alone is granted first.
- Owner drops req in WAIT: done still pulses at the expected cycle; no new grant until IDLE.
